// File: rtl/dmem_ctrl_pkg.sv
// Shared encodings for the data-RAM sequencer: store sizes, FSM states, alignment rule.
// Latency: none (types and a pure function only).
// Backpressure: not applicable.
package dmem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_W   = 2'b00,
    ST_H   = 2'b01,
    ST_B   = 2'b10,
    ST_RSV = 2'b11   // reserved, behaves as a word store
  } store_ctl_e;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_MERGE = 1'b1
  } state_e;

  // A store is misaligned when its lanes do not sit naturally inside the word.
  function automatic logic store_misaligned(input store_ctl_e ctl, input logic [1:0] off);
    logic mis;
    case (ctl)
      ST_H:    mis = off[0];
      ST_B:    mis = 1'b0;
      default: mis = (off != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dmem_ctrl_merge.sv
// Lane merge for sub-word stores: old RAM word with the addressed byte/half replaced.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is written.
module dmem_merge
  import dmem_ctrl_pkg::*;
(
  input  logic [31:0] old_word_i,
  input  logic [15:0] new_data_i,
  input  logic [1:0]  offset_i,
  input  store_ctl_e  size_i,
  output logic [31:0] merged_o
);

  // Replace only the lanes covered by the store; halfwords are already known aligned.
  always_comb begin
    merged_o = old_word_i;
    for (int i = 0; i < 4; i++) begin
      if (size_i == ST_B && offset_i == 2'(i)) begin
        merged_o[8*i +: 8] = new_data_i[7:0];
      end else if (size_i == ST_H && offset_i[1] == i[1]) begin
        merged_o[8*i +: 8] = i[0] ? new_data_i[15:8] : new_data_i[7:0];
      end
    end
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Arbiter/sequencer for the single-port data RAM: memory stage first, external port second.
// Latency: loads/SW issue same cycle; SB/SH take two cycles (read, merge-write); ext grant one cycle after issue.
// Backpressure: StallM holds the pipe for the RMW read cycle and for a forced ext slot; ext waits via ext_gnt.
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int ADDR_W     = 30,
  parameter int STARVE_MAX = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              MemReadM,
  input  logic              MemWriteM,
  input  logic [1:0]        StoreCtlM,
  input  logic [31:0]       ALUResultM,
  input  logic [31:0]       WriteDataM,
  output logic              StallM,
  output logic              MisalignM,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [31:0]       ext_wdata,
  output logic              ext_gnt,
  output logic              ext_rvalid,
  output logic [31:0]       ext_rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_din,
  input  logic [31:0]       ram_dout
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_TOP = CNT_W'(STARVE_MAX);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  starve_q, starve_d;
  logic              gnt_q, gnt_d;
  logic              rvalid_q, rvalid_d;
  logic [ADDR_W-1:0] rmw_addr_q, rmw_addr_d;
  logic [15:0]       rmw_data_q, rmw_data_d;
  logic [1:0]        rmw_off_q, rmw_off_d;
  store_ctl_e        rmw_size_q, rmw_size_d;

  logic              pipe_op;
  logic              starved;
  logic [ADDR_W-1:0] pipe_word;
  logic [1:0]        pipe_off;
  store_ctl_e        pipe_ctl;
  logic [CNT_W-1:0]  starve_inc;
  logic [31:0]       merged;

  assign pipe_op    = MemReadM | MemWriteM;
  assign starved    = (starve_q == STARVE_TOP);
  assign pipe_word  = ALUResultM[ADDR_W+1:2];
  assign pipe_off   = ALUResultM[1:0];
  assign pipe_ctl   = store_ctl_e'(StoreCtlM);
  assign starve_inc = starved ? starve_q : starve_q + 1'b1;

  assign ext_gnt    = gnt_q;
  assign ext_rvalid = rvalid_q;
  assign ext_rdata  = ram_dout;

  dmem_merge u_merge (
    .old_word_i (ram_dout),
    .new_data_i (rmw_data_q),
    .offset_i   (rmw_off_q),
    .size_i     (rmw_size_q),
    .merged_o   (merged)
  );

  // Arbitration, RAM drive and next-state; reset blanks the strobes so an abandoned RMW never writes.
  always_comb begin
    state_d    = state_q;
    starve_d   = starve_q;
    gnt_d      = 1'b0;
    rvalid_d   = 1'b0;
    rmw_addr_d = rmw_addr_q;
    rmw_data_d = rmw_data_q;
    rmw_off_d  = rmw_off_q;
    rmw_size_d = rmw_size_q;
    StallM     = 1'b0;
    MisalignM  = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = pipe_word;
    ram_din    = WriteDataM;

    case (state_q)
      S_IDLE: begin
        if (ext_req && (starved || !pipe_op)) begin
          // External slot: either the pipe is quiet or the ext port has waited long enough.
          ram_addr = ext_addr;
          ram_we   = ext_we;
          ram_din  = ext_wdata;
          gnt_d    = 1'b1;
          rvalid_d = !ext_we;
          starve_d = '0;
          StallM   = pipe_op;
        end else if (pipe_op) begin
          if (ext_req) starve_d = starve_inc;
          if (MemWriteM) begin
            if (store_misaligned(pipe_ctl, pipe_off)) begin
              MisalignM = 1'b1;
            end else if (pipe_ctl == ST_H || pipe_ctl == ST_B) begin
              // Read the old word now, write the merged word next cycle.
              rmw_addr_d = pipe_word;
              rmw_data_d = WriteDataM[15:0];
              rmw_off_d  = pipe_off;
              rmw_size_d = pipe_ctl;
              StallM     = 1'b1;
              state_d    = S_MERGE;
            end else begin
              ram_we = 1'b1;
            end
          end
        end
      end
      S_MERGE: begin
        ram_addr = rmw_addr_q;
        ram_din  = merged;
        ram_we   = 1'b1;
        state_d  = S_IDLE;
        if (ext_req) starve_d = starve_inc;
      end
      default: state_d = S_IDLE;
    endcase

    if (RST) begin
      ram_we    = 1'b0;
      StallM    = 1'b0;
      MisalignM = 1'b0;
    end
  end

  // State, starvation counter, ext response flags and latched RMW operands.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      starve_q   <= '0;
      gnt_q      <= 1'b0;
      rvalid_q   <= 1'b0;
      rmw_addr_q <= '0;
      rmw_data_q <= '0;
      rmw_off_q  <= '0;
      rmw_size_q <= ST_W;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      gnt_q      <= gnt_d;
      rvalid_q   <= rvalid_d;
      rmw_addr_q <= rmw_addr_d;
      rmw_data_q <= rmw_data_d;
      rmw_off_q  <= rmw_off_d;
      rmw_size_q <= rmw_size_d;
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl with a RAM behind it and a transaction-level expectation model.
// Latency: model predicts per cycle; registered ext outputs are checked one cycle after issue.
// Backpressure: the pipe driver holds its request while StallM is high.
module tb_dmem_ctrl;

  localparam int AW   = 30;
  localparam int SMAX = 8;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          MemReadM = 1'b0, MemWriteM = 1'b0;
  logic [1:0]    StoreCtlM = 2'b00;
  logic [31:0]   ALUResultM = '0, WriteDataM = '0;
  logic          StallM, MisalignM;
  logic          ext_req = 1'b0, ext_we = 1'b0;
  logic [AW-1:0] ext_addr = '0;
  logic [31:0]   ext_wdata = '0;
  logic          ext_gnt, ext_rvalid;
  logic [31:0]   ext_rdata;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_din;
  logic [31:0]   ram_dout;

  always #5 CLK = ~CLK;

  dmem_ctrl #(.ADDR_W(AW), .STARVE_MAX(SMAX)) dut (
    .CLK(CLK), .RST(RST),
    .MemReadM(MemReadM), .MemWriteM(MemWriteM), .StoreCtlM(StoreCtlM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .StallM(StallM), .MisalignM(MisalignM),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  // Synchronous single-port RAM, read-before-write.
  logic [31:0] mem [0:1023];
  always @(posedge CLK) begin
    if (ram_we) mem[ram_addr[9:0]] <= ram_din;
    ram_dout <= mem[ram_addr[9:0]];
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- expectation model ----------------
  logic [31:0] mexp [0:1023];
  bit          mkn  [0:1023];
  int          m_starve = 0;
  bit          m_merge  = 0;
  logic [29:0] m_waddr;
  logic [1:0]  m_off;
  logic [1:0]  m_sz;
  logic [15:0] m_data;
  bit          m_gnt = 0, m_rvalid = 0;
  bit          rd_pend = 0, rd_ext = 0, rd_kn = 0;
  logic [31:0] rd_val;

  initial for (int i = 0; i < 1024; i++) mkn[i] = 0;

  always @(negedge CLK) begin : compare
    bit          pipe, mis, e_stall, e_mis, e_we, a_chk, d_chk;
    bit          n_gnt, n_rv, n_pend, n_ext, n_kn;
    logic [29:0] e_addr, wa;
    logic [31:0] e_din, w, n_val;
    logic [1:0]  off;
    if (RST) begin
      chk("rst_StallM", StallM, 0);
      chk("rst_ram_we", ram_we, 0);
      chk("rst_ext_gnt", ext_gnt, 0);
      chk("rst_ext_rvalid", ext_rvalid, 0);
      m_starve = 0; m_merge = 0; m_gnt = 0; m_rvalid = 0; rd_pend = 0;
    end else begin
      chk("ext_gnt", ext_gnt, m_gnt);
      chk("ext_rvalid", ext_rvalid, m_rvalid);
      if (rd_pend && rd_kn) begin
        if (rd_ext) chk("ext_rdata", ext_rdata, rd_val);
        else        chk("load_data", ram_dout, rd_val);
      end
      e_stall = 0; e_mis = 0; e_we = 0; a_chk = 0; d_chk = 0;
      n_gnt = 0; n_rv = 0; n_pend = 0; n_ext = 0; n_kn = 0;
      e_addr = '0; e_din = '0; n_val = '0;
      pipe = MemReadM | MemWriteM;
      wa   = ALUResultM[31:2];
      off  = ALUResultM[1:0];
      if (m_merge) begin
        w = mexp[m_waddr[9:0]];
        if (m_sz == 2'b10) w[8*m_off +: 8]  = m_data[7:0];
        else               w[8*m_off +: 16] = m_data;
        e_we = 1; a_chk = 1; e_addr = m_waddr; e_din = w; d_chk = mkn[m_waddr[9:0]];
        mexp[m_waddr[9:0]] = w;
        if (ext_req && m_starve < SMAX) m_starve++;
        m_merge = 0;
      end else if (ext_req && (m_starve == SMAX || !pipe)) begin
        e_stall = pipe; a_chk = 1; e_addr = ext_addr; e_we = ext_we; e_din = ext_wdata; d_chk = ext_we;
        if (ext_we) begin
          mexp[ext_addr[9:0]] = ext_wdata; mkn[ext_addr[9:0]] = 1;
        end else begin
          n_pend = 1; n_ext = 1; n_val = mexp[ext_addr[9:0]]; n_kn = mkn[ext_addr[9:0]];
        end
        n_gnt = 1; n_rv = !ext_we; m_starve = 0;
      end else if (pipe) begin
        if (ext_req && m_starve < SMAX) m_starve++;
        if (MemWriteM) begin
          mis   = (StoreCtlM == 2'b01) ? off[0] : (StoreCtlM == 2'b10) ? 1'b0 : (off != 2'b00);
          e_mis = mis;
          if (!mis) begin
            a_chk = 1; e_addr = wa;
            if (StoreCtlM == 2'b01 || StoreCtlM == 2'b10) begin
              e_stall = 1; m_merge = 1; m_waddr = wa; m_off = off; m_sz = StoreCtlM;
              m_data = WriteDataM[15:0];
            end else begin
              e_we = 1; e_din = WriteDataM; d_chk = 1;
              mexp[wa[9:0]] = WriteDataM; mkn[wa[9:0]] = 1;
            end
          end
        end else begin
          a_chk = 1; e_addr = wa;
          n_pend = 1; n_ext = 0; n_val = mexp[wa[9:0]]; n_kn = mkn[wa[9:0]];
        end
      end
      chk("StallM", StallM, e_stall);
      chk("MisalignM", MisalignM, e_mis);
      chk("ram_we", ram_we, e_we);
      if (a_chk) chk("ram_addr", {2'b00, ram_addr}, {2'b00, e_addr});
      if (e_we && d_chk) chk("ram_din", ram_din, e_din);
      m_gnt = n_gnt; m_rvalid = n_rv;
      rd_pend = n_pend; rd_ext = n_ext; rd_kn = n_kn; rd_val = n_val;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic pipe_idle();
    MemReadM = 0; MemWriteM = 0; StoreCtlM = 2'b00; ALUResultM = '0; WriteDataM = '0;
  endtask

  // Issue one pipe op and hold it while the DUT stalls; report stall cycles and grants seen.
  task automatic pipe_op(input bit rd, input bit wr, input logic [1:0] ctl,
                         input logic [31:0] a, input logic [31:0] d,
                         output int stalls, output int gnts);
    MemReadM = rd; MemWriteM = wr; StoreCtlM = ctl; ALUResultM = a; WriteDataM = d;
    stalls = 0; gnts = 0;
    for (int k = 0; k < 4; k++) begin
      bit s;
      @(negedge CLK);
      s = StallM;
      if (ext_gnt) gnts++;
      @(posedge CLK); #1;
      if (!s) return;
      stalls++;
    end
    n_chk++; n_fail++;
    $display("FAIL pipe_hold_timeout: stalled %0d cycles, expected at most 1", stalls);
  endtask

  task automatic ext_access(input bit we, input logic [AW-1:0] a, input logic [31:0] d);
    pipe_idle();
    ext_req = 1; ext_we = we; ext_addr = a; ext_wdata = d;
    @(posedge CLK); #1;
    ext_req = 0; ext_we = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got %0d checks, expected completion", n_chk);
    $fatal(1, "timeout");
  end

  initial begin
    int st, gn, tot_st, tot_gn, first_stall, second_stall;
    repeat (2) @(posedge CLK);
    #1 RST = 0;
    chk("after_reset_gnt", ext_gnt, 0);
    chk("after_reset_rvalid", ext_rvalid, 0);

    // Preload through the ext port with an idle pipe.
    ext_access(1, 30'h40, 32'h11223344);
    chk("ext_write_gnt", ext_gnt, 1);
    chk("ext_write_rvalid", ext_rvalid, 0);
    ext_access(1, 30'h41, 32'h01020304);
    ext_access(1, 30'h42, 32'h0A0B0C0D);
    ext_access(1, 30'h43, 32'hF0E0D0C0);
    ext_access(1, 30'h05, 32'h55AA0005);
    ext_access(1, 30'h50, 32'hA5A5A5A5);
    @(posedge CLK); #1;

    // SB 0xAA at byte 0x101 over 0x11223344.
    pipe_op(0, 1, 2'b10, 32'h101, 32'h000000AA, st, gn);
    chk("sb_stall_cycles", st, 1);
    pipe_idle();
    chk("sb_word", mem[10'h40], 32'h1122AA44);

    // SH 0xBEEF at 0x102 over a fresh 0x11223344.
    ext_access(1, 30'h40, 32'h11223344);
    pipe_op(0, 1, 2'b01, 32'h102, 32'h0000BEEF, st, gn);
    chk("sh_stall_cycles", st, 1);
    pipe_idle();
    chk("sh_word", mem[10'h40], 32'hBEEF3344);

    // SH at 0x103: misaligned, suppressed, no stall.
    MemWriteM = 1; StoreCtlM = 2'b01; ALUResultM = 32'h103; WriteDataM = 32'h00001234;
    @(negedge CLK);
    chk("sh_mis_flag", MisalignM, 1);
    chk("sh_mis_stall", StallM, 0);
    @(posedge CLK); #1;
    pipe_idle();
    chk("sh_mis_word", mem[10'h40], 32'hBEEF3344);

    // SW at 0x106: misaligned word store.
    MemWriteM = 1; StoreCtlM = 2'b00; ALUResultM = 32'h106; WriteDataM = 32'hDEADDEAD;
    @(negedge CLK);
    chk("sw_mis_flag", MisalignM, 1);
    @(posedge CLK); #1;
    pipe_idle();
    chk("sw_mis_word", mem[10'h41], 32'h01020304);

    // SB into the top lane of word 0x43.
    pipe_op(0, 1, 2'b10, 32'h10F, 32'h00000077, st, gn);
    pipe_idle();
    chk("sb_lane3_word", mem[10'h43], 32'h77E0D0C0);

    // SW then LW at 0x200, back to back.
    pipe_op(0, 1, 2'b00, 32'h200, 32'hCAFEF00D, st, gn);
    chk("sw_stall", st, 0);
    pipe_op(1, 0, 2'b00, 32'h200, 32'h0, st, gn);
    chk("lw_stall", st, 0);
    pipe_idle();
    chk("lw_data", ram_dout, 32'hCAFEF00D);

    // Read and write together: the write wins.
    pipe_op(1, 1, 2'b00, 32'h204, 32'h0BADBEEF, st, gn);
    pipe_idle();
    chk("rw_write_wins", mem[10'h81], 32'h0BADBEEF);

    // Starvation: ext read of word 5 held high across 20 pipe loads.
    ext_req = 1; ext_we = 0; ext_addr = 30'h05;
    tot_st = 0; tot_gn = 0; first_stall = -1; second_stall = -1;
    for (int i = 0; i < 20; i++) begin
      pipe_op(1, 0, 2'b00, 32'h100 + 32'(4 * (i % 4)), 32'h0, st, gn);
      if (st > 0) begin
        if (first_stall < 0) first_stall = i;
        else if (second_stall < 0) second_stall = i;
      end
      tot_st += st;
      tot_gn += gn;
    end
    ext_req = 0;
    pipe_idle();
    chk("starve_first_slot", first_stall, 8);
    chk("starve_second_slot", second_stall, 16);
    chk("starve_stalls", tot_st, 2);
    chk("starve_grants", tot_gn, 2);

    // Ext read of word 5 with an idle pipe.
    ext_access(0, 30'h05, 32'h0);
    chk("ext_read_gnt", ext_gnt, 1);
    chk("ext_read_rvalid", ext_rvalid, 1);
    chk("ext_read_data", ext_rdata, 32'h55AA0005);
    @(posedge CLK); #1;

    // Async reset in the middle of an SB merge.
    MemWriteM = 1; StoreCtlM = 2'b10; ALUResultM = 32'h141; WriteDataM = 32'h0000005A;
    @(posedge CLK); #1;
    chk("merge_we_before_rst", ram_we, 1);
    #1 RST = 1;
    #1;
    chk("rst_async_ram_we", ram_we, 0);
    chk("rst_async_stall", StallM, 0);
    pipe_idle();
    @(posedge CLK); #1;
    RST = 0;
    @(posedge CLK); #1;
    chk("rst_word_unchanged", mem[10'h50], 32'hA5A5A5A5);
    pipe_op(0, 1, 2'b00, 32'h140, 32'h12345678, st, gn);
    chk("post_rst_sw_stall", st, 0);
    pipe_idle();
    chk("post_rst_sw_word", mem[10'h50], 32'h12345678);

    repeat (3) @(posedge CLK);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
